// File: rtl/acc_deskew_collector.sv
// rtl/acc_deskew_collector.sv - de-skews the systolic acc_z_to_z lane stream into one full matrix
// and holds it on a valid/ready bus until it is accepted.
module acc_deskew_collector #(
    parameter int DATA_SIZE = 16,
    parameter int SIZE      = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DATA_SIZE*SIZE-1:0]      acc_z_to_z,
    output logic [DATA_SIZE*SIZE*SIZE-1:0] mat_out,
    output logic                           mat_valid,
    input  logic                           mat_ready,
    output logic                           busy,
    output logic                           start_dropped
);
    localparam int CNT_W = $clog2(2 * SIZE);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(2 * SIZE - 2);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [DATA_SIZE*SIZE*SIZE-1:0] mat_q, mat_d;
    logic                           drop_q, drop_d;
    logic                           cap_en;
    logic [CNT_W-1:0]               beat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        cap_en  = 1'b0;
        beat    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_en = 1'b1;
                    beat   = '0;
                    if (SIZE == 1) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                drop_d = start;
                if (cnt_q == LAST_BEAT) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // A start on the handshake edge is dropped too; no back-to-back accept.
                drop_d = start;
                if (mat_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Row r sits on lane c at beat r+c, so each beat fills one anti-diagonal.
    always_comb begin
        mat_d = mat_q;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (cap_en && (r + c == int'(beat))) begin
                    mat_d[DATA_SIZE*(SIZE*SIZE-(r*SIZE+c))-1 -: DATA_SIZE] =
                        acc_z_to_z[DATA_SIZE*(SIZE-c)-1 -: DATA_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mat_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat_q   <= mat_d;
            drop_q  <= drop_d;
        end
    end

    assign mat_out       = mat_q;
    assign mat_valid     = (state_q == HOLD);
    assign busy          = (state_q != IDLE);
    assign start_dropped = drop_q;

endmodule

// File: tb/tb_acc_deskew_collector.sv
// tb/tb_acc_deskew_collector.sv - directed bench for acc_deskew_collector with a matrix-level
// reference model for size 3 and literal checks for a size-1 instance.
module tb_acc_deskew_collector;
    localparam int D  = 16;
    localparam int S  = 3;
    localparam int W  = D * S;
    localparam int MW = D * S * S;

    localparam logic [MW-1:0] LIT1 = 144'h0100_0200_0300_0400_0500_0600_0700_0800_0900;
    localparam logic [MW-1:0] LIT4 = 144'h1111_2222_3333_4444_5555_6666_7777_8888_9999;
    localparam logic [MW-1:0] LIT5 = 144'h0010_0020_0030_0040_0050_0060_0070_0080_0090;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, mat_ready;
    logic [W-1:0]  acc;
    logic [MW-1:0] mat_out;
    logic          mat_valid, busy, start_dropped;

    logic          s1_start, s1_ready;
    logic [15:0]   s1_acc, s1_out;
    logic          s1_valid, s1_busy, s1_drop;

    acc_deskew_collector #(.DATA_SIZE(D), .SIZE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_z_to_z(acc),
        .mat_out(mat_out), .mat_valid(mat_valid), .mat_ready(mat_ready),
        .busy(busy), .start_dropped(start_dropped)
    );

    acc_deskew_collector #(.DATA_SIZE(16), .SIZE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .acc_z_to_z(s1_acc),
        .mat_out(s1_out), .mat_valid(s1_valid), .mat_ready(s1_ready),
        .busy(s1_busy), .start_dropped(s1_drop)
    );

    int n_vec = 0;
    int n_err = 0;
    int drop_cnt = 0;
    bit cmp_en = 1'b0;

    logic [15:0] beats[5][3];
    logic [15:0] hold_fill = 16'h0000;

    // Reference model: a matrix of expected elements and where in the matrix lifetime we are.
    logic [15:0] exp_m[3][3];
    bit m_busy = 1'b0, m_hold = 1'b0, m_drop = 1'b0;
    int m_beat = 0;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_of(input logic [W-1:0] v, input int j);
        return v[D*(S-j)-1 -: D];
    endfunction

    function automatic logic [MW-1:0] flat_exp();
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
                v[D*(S*S-(r*S+c))-1 -: D] = exp_m[r][c];
        return v;
    endfunction

    task automatic model_capture(input int k);
        for (int j = 0; j < S; j++) begin
            if (k - j >= 0 && k - j < S) exp_m[k-j][j] = lane_of(acc, j);
        end
    endtask

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_hold = 1'b0; m_drop = 1'b0; m_beat = 0;
            for (int r = 0; r < S; r++)
                for (int c = 0; c < S; c++) exp_m[r][c] = 16'h0;
        end else begin
            m_drop = 1'b0;
            if (m_hold) begin
                m_drop = start;
                if (mat_ready) begin
                    m_hold = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (m_busy) begin
                m_drop = start;
                model_capture(m_beat);
                if (m_beat == 2 * S - 2) m_hold = 1'b1;
                else m_beat++;
            end else if (start) begin
                model_capture(0);
                m_busy = 1'b1;
                m_beat = 1;
            end
        end
    end

    always begin
        @(negedge clk);
        if (cmp_en) begin
            check("valid", {143'b0, mat_valid}, {143'b0, m_hold});
            check("busy", {143'b0, busy}, {143'b0, m_busy});
            check("dropped", {143'b0, start_dropped}, {143'b0, m_drop});
            check("mat", mat_out, flat_exp());
        end
        if (start_dropped) drop_cnt++;
    end

    task automatic fill(input logic [15:0] step);
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < S; j++)
                beats[k][j] = (k - j >= 0 && k - j < S) ? 16'(step * (3 * (k - j) + j + 1)) : 16'h0;
    endtask

    task automatic send(input int drop_at);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = (k == 0) || (k == drop_at);
            for (int j = 0; j < S; j++) acc[D*(S-j)-1 -: D] = beats[k][j];
        end
        @(negedge clk);
        start = 1'b0;
        acc = {S{hold_fill}};
    endtask

    initial begin
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) exp_m[r][c] = 16'h0;
        rst_n = 1'b0; start = 1'b0; mat_ready = 1'b1; acc = '0;
        s1_start = 1'b0; s1_ready = 1'b0; s1_acc = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_mat", mat_out, '0);
        check("rst_valid", {143'b0, mat_valid}, '0);
        check("rst_busy", {143'b0, busy}, '0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // 1: basic capture, ready always high
        fill(16'h0100);
        send(-1);
        check("t1_valid_rise", {143'b0, mat_valid}, 144'd1);
        check("t1_mat", mat_out, LIT1);
        @(negedge clk);
        check("t1_valid_one_cycle", {143'b0, mat_valid}, '0);

        // 2: backpressure with garbage on the lanes
        mat_ready = 1'b0;
        hold_fill = 16'hFFFF;
        send(-1);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", {143'b0, mat_valid}, 144'd1);
            check("t2_hold_mat", mat_out, LIT1);
            @(negedge clk);
        end
        mat_ready = 1'b1;
        @(negedge clk);
        check("t2_valid_fall", {143'b0, mat_valid}, '0);
        hold_fill = 16'h0000;
        acc = '0;

        // 3: starts during capture and on the handshake edge are dropped
        @(negedge clk);
        drop_cnt = 0;
        mat_ready = 1'b0;
        fill(16'h0100);
        send(2);
        mat_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_valid", {143'b0, mat_valid}, '0);
        check("t3_busy", {143'b0, busy}, '0);
        check("t3_drop_pulse", {143'b0, start_dropped}, 144'd1);
        check("t3_mat", mat_out, LIT1);
        @(negedge clk);
        check("t3_drop_count", 144'(drop_cnt), 144'd2);
        check("t3_still_idle", {143'b0, busy}, '0);

        // 4: out-of-window lanes never land in the matrix
        fill(16'h1111);
        beats[0][1] = 16'hDEAD; beats[0][2] = 16'hDEAD;
        beats[4][0] = 16'hBEEF; beats[4][1] = 16'hBEEF;
        send(-1);
        check("t4_mat", mat_out, LIT4);
        for (int e = 0; e < S * S; e++) begin
            logic [15:0] el;
            el = mat_out[D*(S*S-e)-1 -: D];
            check("t4_no_leak", {143'b0, (el == 16'hDEAD) || (el == 16'hBEEF)}, '0);
        end
        @(negedge clk);

        // 5: reset in the middle of a capture
        fill(16'h0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = (k == 0);
            for (int j = 0; j < S; j++) acc[D*(S-j)-1 -: D] = beats[k][j];
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_mat", mat_out, '0);
        check("t5_rst_valid", {143'b0, mat_valid}, '0);
        check("t5_rst_busy", {143'b0, busy}, '0);
        check("t5_rst_drop", {143'b0, start_dropped}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(16'h0010);
        send(-1);
        check("t5_new_mat", mat_out, LIT5);
        check("t5_new_valid", {143'b0, mat_valid}, 144'd1);
        @(negedge clk);

        // 6: size-1 instance
        s1_start = 1'b1; s1_acc = 16'h1234; s1_ready = 1'b0;
        @(negedge clk);
        s1_start = 1'b0; s1_acc = 16'h0000;
        check("t6_valid", {143'b0, s1_valid}, 144'd1);
        check("t6_busy", {143'b0, s1_busy}, 144'd1);
        check("t6_mat", {128'b0, s1_out}, 144'h1234);
        s1_ready = 1'b1;
        @(negedge clk);
        check("t6_valid_fall", {143'b0, s1_valid}, '0);
        check("t6_idle", {143'b0, s1_busy}, '0);
        check("t6_mat_kept", {128'b0, s1_out}, 144'h1234);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
